key_entry_buffer: RTL and testbench
===================================

KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 28'd60000000; inactivity cycles before an entry is abandoned (5 s at 12 MHz).
REQ-002 Parameter MAX_TRIES, default 2'd3; consecutive rejected codes that trigger lockout.
REQ-003 Parameter LOCK_CYC, default 28'd240000000; lockout duration in cycles (20 s at 12 MHz).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 key_valid  input  1  one-cycle strobe from keypad scanner, a key was pressed.
REQ-007 key_code  input  4  key value when key_valid=1: 0-9 digit, 10 '*' (clear), 11 '#' (enter), 12-15 invalid.
REQ-008 pw_ok  input  1  one-cycle verdict from downstream checker, code accepted.
REQ-009 pw_fail  input  1  one-cycle verdict from downstream checker, code rejected.
REQ-010 code  output  16  assembled BCD code, first digit in [15:12], last digit in [3:0].
REQ-011 code_valid  output  1  one-cycle strobe, code complete and stable.
REQ-012 digit_cnt  output  3  digits currently buffered, 0-4.
REQ-013 entry_err  output  1  one-cycle strobe, '#' pressed with fewer than 4 digits.
REQ-014 timeout_flag  output  1  one-cycle strobe, entry abandoned on inactivity.
REQ-015 locked  output  1  level, lockout active; all keys ignored.

Function
REQ-016 States: IDLE, ENTRY, LOCKED; all outputs registered.
REQ-017 IDLE: digit key -> code={12'h000,digit}, digit_cnt=1, inactivity timer cleared, go ENTRY; '*', '#', and codes 12-15 ignored.
REQ-018 ENTRY, digit key, digit_cnt<4 -> code={code[11:0],digit}, digit_cnt+1, timer cleared.
REQ-019 ENTRY, digit key, digit_cnt=4 -> digit discarded, code unchanged, timer cleared.
REQ-020 ENTRY, '*' -> code=0, digit_cnt=0, go IDLE; no strobe.
REQ-021 ENTRY, '#' with digit_cnt=4 -> code_valid=1 on the next cycle (latency 1), code held, digit_cnt=0, go IDLE.
REQ-022 ENTRY, '#' with digit_cnt<4 -> entry_err=1 on the next cycle, code=0, digit_cnt=0, go IDLE.
REQ-023 ENTRY, codes 12-15 -> ignored, timer not cleared.
REQ-024 ENTRY timer increments every cycle without an accepted key; at TIMEOUT_CYC-1 -> timeout_flag=1 on the next cycle, code=0, digit_cnt=0, go IDLE.
REQ-025 Key accepted in the same cycle the timer expires: the key wins, timer cleared, no timeout_flag.
REQ-026 code retains the submitted value after code_valid until the next digit key or reset.
REQ-027 Fail counter (2 bits): pw_fail increments; pw_ok clears; both asserted in the same cycle -> pw_ok wins.
REQ-028 pw_fail bringing the counter to MAX_TRIES -> go LOCKED next cycle, locked=1, code=0, digit_cnt=0, lock timer cleared; this transition overrides any state and any key in that cycle.
REQ-029 LOCKED: key_valid, pw_ok, pw_fail ignored; lock timer counts; at LOCK_CYC-1 -> locked=0, fail counter=0, go IDLE.
REQ-030 Timers are 28 bits and never wrap; each stops at its terminal count.

Reset
REQ-031 rst=1 at a clock edge -> IDLE, code=0, digit_cnt=0, code_valid=0, entry_err=0, timeout_flag=0, locked=0, both timers and the fail counter 0.
REQ-032 Reset mid-entry or mid-lockout aborts the operation with no strobe.

Verification (TIMEOUT_CYC=100, LOCK_CYC=200 for simulation)
REQ-033 Keys 1,2,3,4,'#' -> code_valid one cycle after '#', code=16'h1234, digit_cnt 1,2,3,4,0.
REQ-034 Keys 5,6,'*',7,8,9,0,1,'#' -> code=16'h7890 (5th digit dropped), single code_valid.
REQ-035 Keys 1,2,'#' -> entry_err one cycle, code=0, no code_valid; key 3 then 100 idle cycles -> timeout_flag one cycle, digit_cnt=0.
REQ-036 Three pw_fail pulses -> locked=1 the cycle after the third; keys during the next 199 cycles ignored; locked=0 after 200 cycles, next entry accepted.
REQ-037 pw_fail, pw_fail, pw_ok, pw_fail -> locked stays 0; pw_ok and pw_fail in the same cycle -> counter cleared.
REQ-038 rst asserted after keys 1,2 -> next cycle digit_cnt=0, code=0; key 9 then gives code=16'h0009.

Source files
------------

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: assembles a 4-digit BCD code and tracks rejected codes, locking out after MAX_TRIES.
// All outputs registered, strobes one cycle after the causing key/verdict; no backpressure, every key strobe is consumed or dropped.
module key_entry_buffer #(
  parameter logic [27:0] TIMEOUT_CYC = 28'd60000000,
  parameter logic [1:0]  MAX_TRIES   = 2'd3,
  parameter logic [27:0] LOCK_CYC    = 28'd240000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        pw_ok,
  input  logic        pw_fail,
  output logic [15:0] code,
  output logic        code_valid,
  output logic [2:0]  digit_cnt,
  output logic        entry_err,
  output logic        timeout_flag,
  output logic        locked
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [15:0] code_nxt;
  logic [2:0]  cnt_nxt;
  logic        valid_nxt, err_nxt, timeout_nxt, locked_nxt;
  logic [27:0] idle_tmr, idle_nxt, lock_tmr, lock_nxt;
  logic [1:0]  fail_cnt, fail_nxt, fail_inc;
  logic        is_digit, is_clr, is_ent, lock_trig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      code         <= 16'h0000;
      digit_cnt    <= 3'd0;
      code_valid   <= 1'b0;
      entry_err    <= 1'b0;
      timeout_flag <= 1'b0;
      locked       <= 1'b0;
      idle_tmr     <= 28'd0;
      lock_tmr     <= 28'd0;
      fail_cnt     <= 2'd0;
    end else begin
      state        <= state_nxt;
      code         <= code_nxt;
      digit_cnt    <= cnt_nxt;
      code_valid   <= valid_nxt;
      entry_err    <= err_nxt;
      timeout_flag <= timeout_nxt;
      locked       <= locked_nxt;
      idle_tmr     <= idle_nxt;
      lock_tmr     <= lock_nxt;
      fail_cnt     <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    code_nxt    = code;
    cnt_nxt     = digit_cnt;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    locked_nxt  = locked;
    idle_nxt    = idle_tmr;
    lock_nxt    = lock_tmr;
    fail_nxt    = fail_cnt;

    is_digit  = key_valid && (key_code <= 4'd9);
    is_clr    = key_valid && (key_code == 4'd10);
    is_ent    = key_valid && (key_code == 4'd11);
    fail_inc  = fail_cnt + 2'd1;
    // pw_ok dominates a simultaneous pw_fail, so only a lone fail can trip the lockout
    lock_trig = (state != LOCKED) && pw_fail && !pw_ok && (fail_inc == MAX_TRIES);

    if (state == LOCKED) begin
      if (lock_tmr == LOCK_CYC - 28'd1) begin
        state_nxt  = IDLE;
        locked_nxt = 1'b0;
        fail_nxt   = 2'd0;
      end else begin
        lock_nxt = lock_tmr + 28'd1;
      end
    end else if (lock_trig) begin
      state_nxt  = LOCKED;
      locked_nxt = 1'b1;
      code_nxt   = 16'h0000;
      cnt_nxt    = 3'd0;
      lock_nxt   = 28'd0;
      idle_nxt   = 28'd0;
      fail_nxt   = fail_inc;
    end else begin
      if (pw_ok)
        fail_nxt = 2'd0;
      else if (pw_fail)
        fail_nxt = fail_inc;

      case (state)
        IDLE: begin
          if (is_digit) begin
            code_nxt  = {12'h000, key_code};
            cnt_nxt   = 3'd1;
            idle_nxt  = 28'd0;
            state_nxt = ENTRY;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            idle_nxt = 28'd0;
            if (digit_cnt < 3'd4) begin
              code_nxt = {code[11:0], key_code};
              cnt_nxt  = digit_cnt + 3'd1;
            end
          end else if (is_clr) begin
            code_nxt  = 16'h0000;
            cnt_nxt   = 3'd0;
            state_nxt = IDLE;
          end else if (is_ent) begin
            if (digit_cnt == 3'd4) begin
              valid_nxt = 1'b1;
            end else begin
              err_nxt  = 1'b1;
              code_nxt = 16'h0000;
            end
            cnt_nxt   = 3'd0;
            state_nxt = IDLE;
          end else if (idle_tmr == TIMEOUT_CYC - 28'd1) begin
            timeout_nxt = 1'b1;
            code_nxt    = 16'h0000;
            cnt_nxt     = 3'd0;
            idle_nxt    = 28'd0;
            state_nxt   = IDLE;
          end else begin
            idle_nxt = idle_tmr + 28'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_buffer.sv
// Randomised and directed bench for key_entry_buffer against a digit-queue reference model with a strobe scoreboard.
module tb_key_entry_buffer;

  localparam int TO = 100;
  localparam int LK = 200;
  localparam int MAXT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        pw_ok = 1'b0;
  logic        pw_fail = 1'b0;
  logic [15:0] code;
  logic        code_valid;
  logic [2:0]  digit_cnt;
  logic        entry_err;
  logic        timeout_flag;
  logic        locked;

  key_entry_buffer #(
    .TIMEOUT_CYC(28'd100),
    .MAX_TRIES  (2'd3),
    .LOCK_CYC   (28'd200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .pw_ok       (pw_ok),
    .pw_fail     (pw_fail),
    .code        (code),
    .code_valid  (code_valid),
    .digit_cnt   (digit_cnt),
    .entry_err   (entry_err),
    .timeout_flag(timeout_flag),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: what the outputs should be after the next rising edge.
  int          m_digs[$];
  bit          m_entry = 1'b0;
  bit          m_locked = 1'b0;
  int          m_fails = 0;
  int          m_idle = 0;
  int          m_lock_age = 0;
  logic [15:0] m_code = 16'h0000;

  typedef struct {
    int          kind;   // 1 code_valid, 2 entry_err, 3 timeout_flag
    logic [15:0] code;
  } ev_t;
  ev_t exp_q[$];

  function automatic logic [15:0] pack_digits();
    int v = 0;
    foreach (m_digs[i]) v = v * 16 + m_digs[i];
    return v[15:0];
  endfunction

  task automatic push_ev(input int kind, input logic [15:0] c);
    ev_t e;
    e.kind = kind;
    e.code = c;
    exp_q.push_back(e);
  endtask

  task automatic abandon();
    m_digs.delete();
    m_entry = 1'b0;
    m_idle  = 0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit ok, input bit fl, input bit r);
    if (r) begin
      abandon();
      m_locked   = 1'b0;
      m_fails    = 0;
      m_lock_age = 0;
      m_code     = 16'h0000;
    end else if (m_locked) begin
      m_lock_age++;
      if (m_lock_age == LK) begin
        m_locked = 1'b0;
        m_fails  = 0;
      end
    end else if (fl && !ok && m_fails + 1 == MAXT) begin
      abandon();
      m_locked   = 1'b1;
      m_lock_age = 0;
      m_fails    = MAXT;
      m_code     = 16'h0000;
    end else begin
      if (ok) m_fails = 0;
      else if (fl) m_fails++;
      if (kv && kc <= 9) begin
        if (!m_entry) begin
          m_entry = 1'b1;
          m_digs.delete();
        end
        if (m_digs.size() < 4) m_digs.push_back(kc);
        m_code = pack_digits();
        m_idle = 0;
      end else if (m_entry && kv && kc == 10) begin
        abandon();
        m_code = 16'h0000;
      end else if (m_entry && kv && kc == 11) begin
        if (m_digs.size() == 4) begin
          push_ev(1, m_code);
        end else begin
          push_ev(2, 16'h0000);
          m_code = 16'h0000;
        end
        abandon();
      end else if (m_entry) begin
        m_idle++;
        if (m_idle == TO) begin
          push_ev(3, 16'h0000);
          abandon();
          m_code = 16'h0000;
        end
      end
    end
  endtask

  task automatic drive(input bit kv, input int kc, input bit ok, input bit fl, input bit r);
    @(negedge clk);
    key_valid = kv;
    key_code  = kc[3:0];
    pw_ok     = ok;
    pw_fail   = fl;
    rst       = r;
    model_step(kv, kc, ok, fl, r);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input int k);
    drive(1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic keys(input int ks[$]);
    foreach (ks[i]) key(ks[i]);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: levels against the model every cycle, strobes against the scoreboard queue.
  initial begin
    ev_t e;
    int  kind;
    int  nstb;
    forever begin
      @(posedge clk);
      #1;
      check("digit_cnt", int'(digit_cnt), m_digs.size());
      check("code", int'(code), int'(m_code));
      check("locked", int'(locked), int'(m_locked));
      nstb = int'(code_valid) + int'(entry_err) + int'(timeout_flag);
      if (nstb != 0) begin
        check("one_strobe", nstb, 1);
        kind = code_valid ? 1 : (entry_err ? 2 : 3);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", kind, 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", kind, e.kind);
          if (kind == 1) check("valid_code", int'(code), int'(e.code));
        end
      end
    end
  end

  initial begin
    int k, gap, r;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    keys('{1, 2, 3, 4, 11});
    idle(3);
    keys('{5, 6, 10, 7, 8, 9, 0, 1, 11});
    idle(2);
    keys('{1, 2, 11});
    idle(2);
    key(3);
    idle(TO + 2);

    // key landing exactly on the expiry cycle beats the timeout
    key(1);
    idle(TO - 1);
    key(2);
    idle(TO - 1);
    idle(3);

    // invalid codes do not restart the inactivity timer
    key(4);
    idle(50);
    key(13);
    idle(52);
    keys('{10, 11, 12, 15});
    idle(2);

    // lockout: keys and verdicts during the lock are ignored
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(1);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    key(5);
    drive(1'b1, 6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < LK - 1; i++)
      drive(1'b1, $urandom_range(11, 0), $urandom_range(1, 0), $urandom_range(1, 0), 1'b0);
    idle(2);
    keys('{9, 8, 7, 6, 11});
    idle(2);

    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(3);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // reset mid-entry and mid-lockout
    keys('{1, 2});
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    key(9);
    idle(2);
    repeat (3) drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(20);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    keys('{4, 3, 2, 1, 11});
    idle(2);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(99, 0);
      if (r < 60)      k = $urandom_range(9, 0);
      else if (r < 78) k = 11;
      else if (r < 85) k = 10;
      else             k = $urandom_range(15, 12);
      drive(1'b1, k, ($urandom_range(99, 0) < 3), ($urandom_range(99, 0) < 3),
            ($urandom_range(999, 0) < 4));
      gap = ($urandom_range(99, 0) < 3) ? $urandom_range(TO + 5, TO - 5) : $urandom_range(3, 0);
      idle(gap);
    end
    idle(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
